// File: rtl/pixel_fifo_sc.sv
// Single-clock pixel FIFO with a registered output pixel, fill-level reporting,
// almost-full throttling, synchronous flush and sticky overflow/underflow flags.
module pixel_fifo_sc #(
  parameter int CH_W      = 8,
  parameter int CHANNELS  = 3,
  parameter int ADDR_W    = 4,
  parameter int AF_MARGIN = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [CH_W*CHANNELS-1:0] din,
  input  logic                     rd_fifo,
  input  logic                     flush,
  output logic [CH_W*CHANNELS-1:0] pixel,
  output logic                     pixel_valid,
  output logic                     full,
  output logic                     almost_full,
  output logic                     fifo_empty,
  output logic [ADDR_W:0]          level,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int W     = CH_W * CHANNELS;
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [ADDR_W:0]   LVL_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   LVL_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LVL_AF   = (ADDR_W+1)'(DEPTH - AF_MARGIN);
  localparam logic [ADDR_W-1:0] PTR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]      PIX_ZERO = {W{1'b0}};

  logic [W-1:0]      r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_level;
  logic [W-1:0]      r_pixel;
  logic              r_pixel_valid;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_empty;
  logic              w_full;
  logic              w_almost_full;
  logic              w_rd_acc;
  logic              w_wr_acc;
  logic              w_ovf_set;
  logic              w_unf_set;
  logic [ADDR_W:0]   w_level_nxt;

  // Status decode and request acceptance; flush masks every request.
  always_comb begin
    w_empty       = (r_level == LVL_ZERO);
    w_full        = (r_level == LVL_FULL);
    w_almost_full = (r_level >= LVL_AF);
    w_rd_acc      = 1'b0;
    w_wr_acc      = 1'b0;
    w_ovf_set     = 1'b0;
    w_unf_set     = 1'b0;
    if (flush) begin
      w_rd_acc  = 1'b0;
      w_wr_acc  = 1'b0;
      w_ovf_set = 1'b0;
      w_unf_set = 1'b0;
    end else begin
      // a write at full is still taken when a read frees a slot in the same cycle
      w_rd_acc  = rd_fifo & ~w_empty;
      w_wr_acc  = wr_en & (~w_full | w_rd_acc);
      w_ovf_set = wr_en & ~w_wr_acc;
      w_unf_set = rd_fifo & w_empty;
    end
  end

  // Next occupancy: a simultaneous push and pop leave the level unchanged.
  always_comb begin
    w_level_nxt = r_level;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_level_nxt = r_level + LVL_ONE;
      2'b01:   w_level_nxt = r_level - LVL_ONE;
      default: w_level_nxt = r_level;
    endcase
  end

  // Storage array; contents are not reset and are don't-care after flush.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers and level counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= PTR_ZERO;
      r_rd_ptr <= PTR_ZERO;
      r_level  <= LVL_ZERO;
    end else if (flush) begin
      r_wr_ptr <= PTR_ZERO;
      r_rd_ptr <= PTR_ZERO;
      r_level  <= LVL_ZERO;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      r_level <= w_level_nxt;
    end
  end

  // Output pixel register; idle cycles show black.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pixel       <= PIX_ZERO;
      r_pixel_valid <= 1'b0;
    end else if (w_rd_acc) begin
      r_pixel       <= r_mem[r_rd_ptr];
      r_pixel_valid <= 1'b1;
    end else begin
      r_pixel       <= PIX_ZERO;
      r_pixel_valid <= 1'b0;
    end
  end

  // Sticky error flags, cleared only by flush or reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= r_overflow | w_ovf_set;
      r_underflow <= r_underflow | w_unf_set;
    end
  end

  assign pixel       = r_pixel;
  assign pixel_valid = r_pixel_valid;
  assign full        = w_full;
  assign almost_full = w_almost_full;
  assign fifo_empty  = w_empty;
  assign level       = r_level;
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;

endmodule

// File: tb/tb_pixel_fifo_sc.sv
// Bench for pixel_fifo_sc: default 16x24 instance plus a 4x20 instance, both driven
// by directed then random traffic and compared every cycle against queue models.
module tb_pixel_fifo_sc;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [23:0] din;
  logic        rd_fifo;
  logic        flush;

  logic [23:0] a_pixel;
  logic        a_valid, a_full, a_af, a_empty, a_ov, a_un;
  logic [4:0]  a_level;

  logic [19:0] b_pixel;
  logic        b_valid, b_full, b_af, b_empty, b_ov, b_un;
  logic [2:0]  b_level;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  pixel_fifo_sc #(.CH_W(8), .CHANNELS(3), .ADDR_W(4), .AF_MARGIN(2)) u_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_fifo(rd_fifo), .flush(flush),
    .pixel(a_pixel), .pixel_valid(a_valid), .full(a_full), .almost_full(a_af),
    .fifo_empty(a_empty), .level(a_level), .overflow(a_ov), .underflow(a_un));

  pixel_fifo_sc #(.CH_W(5), .CHANNELS(4), .ADDR_W(2), .AF_MARGIN(1)) u_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din[19:0]), .rd_fifo(rd_fifo), .flush(flush),
    .pixel(b_pixel), .pixel_valid(b_valid), .full(b_full), .almost_full(b_af),
    .fifo_empty(b_empty), .level(b_level), .overflow(b_ov), .underflow(b_un));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference models: plain queues, evaluated with the inputs present at each edge.
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] ma_pix, mb_pix;
  logic        ma_val, mb_val, ma_ov, mb_ov, ma_un, mb_un;
  logic        ra, wa, rb, wb;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      qa.delete(); ma_pix = 0; ma_val = 0; ma_ov = 0; ma_un = 0;
    end else if (flush) begin
      qa.delete(); ma_pix = 0; ma_val = 0; ma_ov = 0; ma_un = 0;
    end else begin
      ra = rd_fifo && (qa.size() > 0);
      wa = wr_en && ((qa.size() < 16) || ra);
      if (rd_fifo && qa.size() == 0) ma_un = 1;
      if (wr_en && !wa) ma_ov = 1;
      if (ra) begin ma_pix = qa.pop_front(); ma_val = 1; end
      else begin ma_pix = 0; ma_val = 0; end
      if (wa) qa.push_back({8'h00, din});
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      qb.delete(); mb_pix = 0; mb_val = 0; mb_ov = 0; mb_un = 0;
    end else if (flush) begin
      qb.delete(); mb_pix = 0; mb_val = 0; mb_ov = 0; mb_un = 0;
    end else begin
      rb = rd_fifo && (qb.size() > 0);
      wb = wr_en && ((qb.size() < 4) || rb);
      if (rd_fifo && qb.size() == 0) mb_un = 1;
      if (wr_en && !wb) mb_ov = 1;
      if (rb) begin mb_pix = qb.pop_front(); mb_val = 1; end
      else begin mb_pix = 0; mb_val = 0; end
      if (wb) qb.push_back({12'h000, din[19:0]});
    end
  end

  // Every-cycle comparison of both instances against their models.
  always @(negedge clk) begin
    if (!rst) begin
      chk("a_pixel", {8'h00, a_pixel}, ma_pix);
      chk("a_valid", {31'd0, a_valid}, {31'd0, ma_val});
      chk("a_level", {27'd0, a_level}, qa.size());
      chk("a_full", {31'd0, a_full}, {31'd0, qa.size() == 16});
      chk("a_almost_full", {31'd0, a_af}, {31'd0, qa.size() >= 14});
      chk("a_empty", {31'd0, a_empty}, {31'd0, qa.size() == 0});
      chk("a_overflow", {31'd0, a_ov}, {31'd0, ma_ov});
      chk("a_underflow", {31'd0, a_un}, {31'd0, ma_un});
      chk("b_pixel", {12'h000, b_pixel}, mb_pix);
      chk("b_valid", {31'd0, b_valid}, {31'd0, mb_val});
      chk("b_level", {29'd0, b_level}, qb.size());
      chk("b_full", {31'd0, b_full}, {31'd0, qb.size() == 4});
      chk("b_almost_full", {31'd0, b_af}, {31'd0, qb.size() >= 3});
      chk("b_empty", {31'd0, b_empty}, {31'd0, qb.size() == 0});
      chk("b_overflow", {31'd0, b_ov}, {31'd0, mb_ov});
      chk("b_underflow", {31'd0, b_un}, {31'd0, mb_un});
    end
  end

  task automatic step(input logic w, input logic [23:0] d, input logic r, input logic f);
    wr_en = w; din = d; rd_fifo = r; flush = f;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; din = 24'h0; rd_fifo = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_empty", {31'd0, a_empty}, 32'd1);
    chk("rst_level", {27'd0, a_level}, 32'd0);
    chk("rst_full", {31'd0, a_full}, 32'd0);
    chk("rst_pixel", {8'h00, a_pixel}, 32'd0);

    // Basic flow: level 0->1->2->1->0
    step(1'b1, 24'h112233, 1'b0, 1'b0); chk("bf_lvl1", {27'd0, a_level}, 32'd1);
    step(1'b1, 24'h445566, 1'b0, 1'b0); chk("bf_lvl2", {27'd0, a_level}, 32'd2);
    step(1'b0, 24'h0, 1'b1, 1'b0);
    chk("bf_pix0", {8'h00, a_pixel}, 32'h112233); chk("bf_val0", {31'd0, a_valid}, 32'd1);
    step(1'b0, 24'h0, 1'b1, 1'b0);
    chk("bf_pix1", {8'h00, a_pixel}, 32'h445566); chk("bf_empty", {31'd0, a_empty}, 32'd1);

    // Fill, almost-full at 14, full at 16, dropped 17th write
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 24'h000100 + 24'(i), 1'b0, 1'b0);
      if (i == 12) chk("af_at13", {31'd0, a_af}, 32'd0);
      if (i == 13) chk("af_at14", {31'd0, a_af}, 32'd1);
      if (i == 14) chk("full_at15", {31'd0, a_full}, 32'd0);
    end
    chk("full_at16", {31'd0, a_full}, 32'd1);
    step(1'b1, 24'h00DEAD, 1'b0, 1'b0);
    chk("ovf_set", {31'd0, a_ov}, 32'd1); chk("ovf_lvl", {27'd0, a_level}, 32'd16);
    step(1'b0, 24'h0, 1'b0, 1'b1);
    chk("flush_ovf", {31'd0, a_ov}, 32'd0);

    // Refill, then simultaneous read+write at full, then drain across wrap
    for (int i = 0; i < 16; i++) step(1'b1, 24'h000200 + 24'(i), 1'b0, 1'b0);
    step(1'b1, 24'h777777, 1'b1, 1'b0);
    chk("sim_pix", {8'h00, a_pixel}, 32'h200); chk("sim_lvl", {27'd0, a_level}, 32'd16);
    chk("sim_ovf", {31'd0, a_ov}, 32'd0);
    for (int i = 1; i < 16; i++) begin
      step(1'b0, 24'h0, 1'b1, 1'b0);
      chk("drain", {8'h00, a_pixel}, 32'h200 + i);
    end
    step(1'b0, 24'h0, 1'b1, 1'b0);
    chk("drain_last", {8'h00, a_pixel}, 32'h777777);

    // Underflow, then write+read while empty
    step(1'b0, 24'h0, 1'b1, 1'b0);
    chk("unf_set", {31'd0, a_un}, 32'd1); chk("unf_val", {31'd0, a_valid}, 32'd0);
    chk("unf_pix", {8'h00, a_pixel}, 32'd0);
    step(1'b1, 24'h123456, 1'b1, 1'b0);
    chk("wr_empty_lvl", {27'd0, a_level}, 32'd1); chk("wr_empty_val", {31'd0, a_valid}, 32'd0);

    // Flush priority at level 5
    for (int i = 0; i < 4; i++) step(1'b1, 24'h300000 + 24'(i), 1'b0, 1'b0);
    chk("pre_flush_lvl", {27'd0, a_level}, 32'd5);
    step(1'b1, 24'h999999, 1'b1, 1'b1);
    chk("fl_lvl", {27'd0, a_level}, 32'd0); chk("fl_empty", {31'd0, a_empty}, 32'd1);
    chk("fl_val", {31'd0, a_valid}, 32'd0); chk("fl_unf", {31'd0, a_un}, 32'd0);
    step(1'b1, 24'hABCDEF, 1'b0, 1'b0);
    step(1'b0, 24'h0, 1'b1, 1'b0);
    chk("fl_readback", {8'h00, a_pixel}, 32'hABCDEF);

    // Random traffic in write-heavy, read-heavy and balanced segments
    for (int k = 0; k < 3000; k++) begin
      int seg;
      int wp;
      int rp;
      seg = (k / 100) % 3;
      wp = (seg == 0) ? 80 : (seg == 1) ? 30 : 50;
      rp = (seg == 0) ? 30 : (seg == 1) ? 80 : 50;
      if (k == 1500) begin
        wr_en = 1'b1; rd_fifo = 1'b1; flush = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      step($urandom_range(0, 99) < wp, 24'($urandom), $urandom_range(0, 99) < rp,
           $urandom_range(0, 99) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
